// File: rtl/step_ramp_gen_if.sv
// Move-command handshake between a motion controller and step_ramp_gen.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can accept a command (slave -> master)
//   cmd_dir   : direction, 1 = forward phase order (master -> slave)
//   cmd_steps : number of steps to issue (master -> slave)
interface step_ramp_gen_if #(
    parameter int unsigned CNT_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/step_ramp_gen.sv
// Trapezoidal step-pulse generator feeding the unipolar phase sequencer.
// Accepts a move command (direction, step count) and emits one-cycle step
// strobes whose spacing ramps from MAX_PERIOD down to MIN_PERIOD and back.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   cmd        : command handshake (slave side); cmd_ready decoded from state
//   abort      : stop the current move immediately
//   step_pulse : one-cycle strobe per step
//   step_dir   : direction latched at command accept
//   busy       : move in progress
//   done       : one-cycle strobe when a move ends (normal or abort)
//   aborted    : one-cycle strobe with done, only on abort
//   steps_left : steps remaining in the current move
module step_ramp_gen #(
    parameter int unsigned MAX_PERIOD = 120000,
    parameter int unsigned MIN_PERIOD = 30000,
    parameter int unsigned ACCEL_STEP = 3000,
    parameter int unsigned CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    step_ramp_gen_if.slave       cmd,
    input  logic                 abort,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_W-1:0]     steps_left
);

    localparam int unsigned PW = 24;
    localparam int unsigned AW = 25;

    localparam logic [PW-1:0] MAX_P = PW'(MAX_PERIOD);
    localparam logic [PW-1:0] MIN_P = PW'(MIN_PERIOD);
    localparam logic [AW-1:0] MAX_A = AW'(MAX_PERIOD);
    localparam logic [AW-1:0] MIN_A = AW'(MIN_PERIOD);
    localparam logic [AW-1:0] ACC_A = AW'(ACCEL_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [PW-1:0]    period, period_d;
    logic [PW-1:0]    timer, timer_d;
    logic [CNT_W-1:0] ramp_cnt, ramp_d;
    logic [CNT_W-1:0] steps_d, steps_r;
    logic             dir_d, busy_d, pulse_d, done_d, aborted_d;

    // Ramp arithmetic in 25 bits so the add cannot overflow and the
    // subtract's sign bit flags an underflow below zero.
    logic [AW-1:0]    period_up_w, period_dn_w;
    logic [PW-1:0]    period_up;
    logic             dn_floor;
    logic [CNT_W-1:0] ramp_inc, ramp_dec;

    assign period_up_w = {1'b0, period} + ACC_A;
    assign period_dn_w = {1'b0, period} - ACC_A;
    assign period_up   = (period_up_w > MAX_A) ? MAX_P : period_up_w[PW-1:0];
    assign dn_floor    = period_dn_w[AW-1] || (period_dn_w <= MIN_A);
    assign ramp_inc    = ramp_cnt + CNT_W'(1);
    assign ramp_dec    = (ramp_cnt == '0) ? '0 : ramp_cnt - CNT_W'(1);

    assign cmd.cmd_ready = (state == IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            period     <= '0;
            timer      <= '0;
            ramp_cnt   <= '0;
            steps_left <= '0;
            step_dir   <= 1'b0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_d;
            period     <= period_d;
            timer      <= timer_d;
            ramp_cnt   <= ramp_d;
            steps_left <= steps_d;
            step_dir   <= dir_d;
            busy       <= busy_d;
            step_pulse <= pulse_d;
            done       <= done_d;
            aborted    <= aborted_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        period_d  = period;
        timer_d   = timer;
        ramp_d    = ramp_cnt;
        steps_d   = steps_left;
        dir_d     = step_dir;
        busy_d    = busy;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        steps_r   = steps_left - CNT_W'(1);

        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d   = cmd.cmd_dir;
                    steps_d = cmd.cmd_steps;
                    if (cmd.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        period_d = MAX_P;
                        timer_d  = MAX_P;
                        ramp_d   = '0;
                        busy_d   = 1'b1;
                        state_d  = ACCEL;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d   = IDLE;
                    steps_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (steps_left == '0) begin
                    // Final strobe went out last cycle; finish so done
                    // and cmd_ready rise together.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (timer == PW'(1)) begin
                    pulse_d = 1'b1;
                    steps_d = steps_r;
                    if (steps_r != '0) begin
                        case (state)
                            ACCEL: begin
                                if (steps_r <= ramp_cnt) begin
                                    state_d  = DECEL;
                                    period_d = period_up;
                                    ramp_d   = ramp_dec;
                                end else if (dn_floor) begin
                                    state_d  = CRUISE;
                                    period_d = MIN_P;
                                    ramp_d   = ramp_inc;
                                end else begin
                                    period_d = period_dn_w[PW-1:0];
                                    ramp_d   = ramp_inc;
                                end
                            end
                            CRUISE: begin
                                if (steps_r <= ramp_cnt) begin
                                    state_d  = DECEL;
                                    period_d = period_up;
                                    ramp_d   = ramp_dec;
                                end
                            end
                            default: begin
                                period_d = period_up;
                                ramp_d   = ramp_dec;
                            end
                        endcase
                        timer_d = period_d;
                    end
                end else begin
                    timer_d = timer - PW'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen with MAX=100, MIN=40, ACCEL_STEP=20.
module tb_step_ramp_gen;

    localparam int unsigned CNT_W = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             abort = 1'b0;
    logic             step_pulse, step_dir, busy, done, aborted;
    logic [CNT_W-1:0] steps_left;

    step_ramp_gen_if #(.CNT_W(CNT_W)) cmd_if ();

    step_ramp_gen #(
        .MAX_PERIOD(100),
        .MIN_PERIOD(40),
        .ACCEL_STEP(20),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if.slave),
        .abort     (abort),
        .step_pulse(step_pulse),
        .step_dir  (step_dir),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Observations gathered over one move
    int               iv_q[$];
    int               sl_q[$];
    int               acc_cyc;
    int               done_gap;
    int               dir_bad;
    int               busy_hi;
    logic             done_aborted, done_busy, done_ready;
    logic [CNT_W-1:0] done_sl;
    bit               timed_out;

    // Present a command; returns #1 after the accepting edge.
    task automatic send_cmd(input logic d, input logic [CNT_W-1:0] n);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_steps = n;
        @(posedge clk); #1;
        acc_cyc          = cyc;
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Record strobe intervals until done; optionally raise abort for the
    // cycle in which strobe (abort_after+1) is due, abort_gap after strobe abort_after.
    task automatic collect(input logic exp_dir, input int abort_after, input int abort_gap);
        int last;
        last = acc_cyc;
        iv_q.delete();
        sl_q.delete();
        dir_bad   = 0;
        done_gap  = -1;
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            abort = 1'b0;
            if (step_pulse) begin
                iv_q.push_back(cyc - last);
                sl_q.push_back(int'(steps_left));
                last = cyc;
                if (step_dir !== exp_dir) dir_bad++;
            end
            if (done) begin
                done_gap     = cyc - last;
                done_aborted = aborted;
                done_busy    = busy;
                done_ready   = cmd_if.cmd_ready;
                done_sl      = steps_left;
                timed_out    = 1'b0;
                break;
            end
            if (abort_after > 0 && iv_q.size() == abort_after && (cyc - last) == abort_gap - 1)
                abort = 1'b1;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_steps = CNT_W'(5);
        #1;
        checks++;
        if ({cmd_if.cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_left} !== {6'b100000, 12'd0}) begin
            errors++;
            $display("FAIL reset_values: got ready/pulse/dir/busy/done/aborted/left=%b %0d, want 100000 0",
                     {cmd_if.cmd_ready, step_pulse, step_dir, busy, done, aborted}, steps_left);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, step_dir, steps_left} !== {2'b00, 12'd0}) begin
            errors++;
            $display("FAIL reset_ignores_cmd: busy=%b dir=%b left=%0d, want 0 0 0", busy, step_dir, steps_left);
        end
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp8();
        int exp_iv[8];
        exp_iv = '{100, 80, 60, 40, 40, 60, 80, 100};
        send_cmd(1'b1, CNT_W'(8));
        checks++;
        if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ramp8_accept: busy=%b ready=%b, want 1 0", busy, cmd_if.cmd_ready);
        end
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL ramp8_timeout: got no done, want done"); end
        checks++;
        if (iv_q.size() != 8) begin
            errors++;
            $display("FAIL ramp8_count: got %0d strobes, want 8", iv_q.size());
        end
        for (int i = 0; i < 8 && i < iv_q.size(); i++) begin
            checks++;
            if (iv_q[i] != exp_iv[i]) begin
                errors++;
                $display("FAIL ramp8_interval[%0d]: got %0d, want %0d", i, iv_q[i], exp_iv[i]);
            end
            checks++;
            if (sl_q[i] != 7 - i) begin
                errors++;
                $display("FAIL ramp8_steps_left[%0d]: got %0d, want %0d", i, sl_q[i], 7 - i);
            end
        end
        checks++;
        if (dir_bad != 0) begin errors++; $display("FAIL ramp8_dir: got %0d bad strobes, want 0", dir_bad); end
        checks++;
        if (done_gap != 1 || done_busy !== 1'b0 || done_ready !== 1'b1 || done_aborted !== 1'b0) begin
            errors++;
            $display("FAIL ramp8_done: gap=%0d busy=%b ready=%b aborted=%b, want 1 0 1 0",
                     done_gap, done_busy, done_ready, done_aborted);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || step_dir !== 1'b1) begin
            errors++;
            $display("FAIL ramp8_after: done=%b dir=%b, want 0 1", done, step_dir);
        end
    endtask

    task automatic test_short();
        int exp3[3];
        exp3 = '{100, 80, 100};
        send_cmd(1'b1, CNT_W'(2));
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out || iv_q.size() != 2 || done_gap != 1) begin
            errors++;
            $display("FAIL short2_shape: timeout=%0d count=%0d gap=%0d, want 0 2 1", timed_out, iv_q.size(), done_gap);
        end else begin
            checks++;
            if (iv_q[0] != 100 || iv_q[1] != 80) begin
                errors++;
                $display("FAIL short2_intervals: got %0d %0d, want 100 80", iv_q[0], iv_q[1]);
            end
        end
        send_cmd(1'b1, CNT_W'(1));
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out || iv_q.size() != 1 || done_gap != 1) begin
            errors++;
            $display("FAIL short1_shape: timeout=%0d count=%0d gap=%0d, want 0 1 1", timed_out, iv_q.size(), done_gap);
        end else begin
            checks++;
            if (iv_q[0] != 100) begin
                errors++;
                $display("FAIL short1_interval: got %0d, want 100", iv_q[0]);
            end
        end
        send_cmd(1'b1, CNT_W'(3));
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out || iv_q.size() != 3) begin
            errors++;
            $display("FAIL short3_count: timeout=%0d count=%0d, want 0 3", timed_out, iv_q.size());
        end
        for (int i = 0; i < 3 && i < iv_q.size(); i++) begin
            checks++;
            if (iv_q[i] != exp3[i]) begin
                errors++;
                $display("FAIL short3_interval[%0d]: got %0d, want %0d", i, iv_q[i], exp3[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        busy_hi = 0;
        send_cmd(1'b0, CNT_W'(0));
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || step_dir !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b dir=%b aborted=%b, want 1 0 0 0", done, busy, step_dir, aborted);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy || step_pulse || done) busy_hi++;
        end
        checks++;
        if (busy_hi != 0) begin
            errors++;
            $display("FAIL zero_quiet: got %0d cycles with busy/pulse/done, want 0", busy_hi);
        end
    endtask

    task automatic test_abort();
        send_cmd(1'b0, CNT_W'(8));
        collect(1'b0, 2, 60);
        checks++;
        if (timed_out || iv_q.size() != 2) begin
            errors++;
            $display("FAIL abort_count: timeout=%0d count=%0d, want 0 2", timed_out, iv_q.size());
        end
        checks++;
        if (done_gap != 60 || done_aborted !== 1'b1 || done_sl !== '0 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: gap=%0d aborted=%b left=%0d busy=%b, want 60 1 0 0",
                     done_gap, done_aborted, done_sl, done_busy);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: done=%b aborted=%b busy=%b ready=%b, want 0 0 0 1",
                     done, aborted, busy, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b1, CNT_W'(1));
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out || done_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: timeout=%0d ready=%b, want 0 1", timed_out, done_ready);
        end
        send_cmd(1'b0, CNT_W'(2));
        checks++;
        if (busy !== 1'b1 || step_dir !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b dir=%b, want 1 0", busy, step_dir);
        end
        collect(1'b0, 0, 0);
        checks++;
        if (timed_out || iv_q.size() != 2 || dir_bad != 0) begin
            errors++;
            $display("FAIL b2b_second: timeout=%0d count=%0d dir_bad=%0d, want 0 2 0", timed_out, iv_q.size(), dir_bad);
        end else begin
            checks++;
            if (iv_q[0] != 100 || iv_q[1] != 80) begin
                errors++;
                $display("FAIL b2b_intervals: got %0d %0d, want 100 80", iv_q[0], iv_q[1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_move();
        int exp4[4];
        int stray;
        exp4  = '{100, 80, 60, 80};
        stray = 0;
        send_cmd(1'b1, CNT_W'(8));
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midreset_prebusy: busy=%b, want 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_if.cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_left} !== {6'b100000, 12'd0}) begin
            errors++;
            $display("FAIL midreset_values: got ready/pulse/dir/busy/done/aborted/left=%b %0d, want 100000 0",
                     {cmd_if.cmd_ready, step_pulse, step_dir, busy, done, aborted}, steps_left);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = CNT_W'(3);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || steps_left !== '0) begin
            errors++;
            $display("FAIL midreset_hold: busy=%b left=%0d, want 0 0", busy, steps_left);
        end
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done || step_pulse || busy) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midreset_stray: got %0d active cycles, want 0", stray); end
        send_cmd(1'b1, CNT_W'(4));
        collect(1'b1, 0, 0);
        checks++;
        if (timed_out || iv_q.size() != 4 || done_aborted !== 1'b0) begin
            errors++;
            $display("FAIL midreset_move: timeout=%0d count=%0d aborted=%b, want 0 4 0", timed_out, iv_q.size(), done_aborted);
        end
        for (int i = 0; i < 4 && i < iv_q.size(); i++) begin
            checks++;
            if (iv_q[i] != exp4[i]) begin
                errors++;
                $display("FAIL midreset_interval[%0d]: got %0d, want %0d", i, iv_q[i], exp4[i]);
            end
        end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = '0;
        test_reset();
        test_ramp8();
        test_short();
        test_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
